// File: rtl/vga_mon_pkg.sv
// vga_mon_pkg: shared definitions for the VGA frame monitor.
//   - default 640x480@60 timing constants (counts in pixel clocks / lines)
//   - monitor FSM state encoding
//   - CRC-16-CCITT word-update helper used by the optional frame CRC
package vga_mon_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_TOTAL  = 800;
   localparam int DEF_H_START  = 144;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_TOTAL  = 525;
   localparam int DEF_V_START  = 35;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h1021;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } mon_state_t;

   // Shift one 16-bit word through the CRC register, MSB first.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                              input logic [15:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         if ((c[15] ^ data[i]) == 1'b1) begin
            c = {c[14:0], 1'b0} ^ CRC_POLY;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/vga_mon_crc16.sv
// vga_mon_crc16: per-frame CRC-16-CCITT over active pixels.
// Ports:
//   clk, reset    pixel clock, synchronous active-high reset
//   clear         hold the accumulator at its initial value (monitor not locked)
//   pix_valid     pix_rgb carries an active pixel this cycle
//   pix_rgb       9-bit pixel, zero-extended to 16 bits before hashing
//   frame_start   frame boundary: publish the running CRC and restart
//   frame_crc     CRC of the previous frame (held until the next boundary)
//   crc_valid     one-cycle strobe when frame_crc is updated
// Inputs are the monitor's next-cycle values so frame_crc/crc_valid line up
// with the registered frame_start output.
module vga_mon_crc16
   import vga_mon_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        pix_valid,
   input  logic [8:0]  pix_rgb,
   input  logic        frame_start,
   output logic [15:0] frame_crc,
   output logic        crc_valid
);

   logic [15:0] acc_r;
   logic [15:0] base_s;
   logic [15:0] acc_s;

   // Next accumulator: restart at a boundary or while unlocked, then fold in the pixel.
   always_comb begin
      base_s = acc_r;
      acc_s  = acc_r;
      if ((frame_start | clear) == 1'b1) begin
         base_s = CRC_INIT;
      end else begin
         base_s = acc_r;
      end
      if (pix_valid == 1'b1) begin
         acc_s = crc16_word(base_s, {7'd0, pix_rgb});
      end else begin
         acc_s = base_s;
      end
   end

   // Accumulator and published result.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r     <= CRC_INIT;
         frame_crc <= 16'd0;
         crc_valid <= 1'b0;
      end else begin
         acc_r     <= acc_s;
         crc_valid <= frame_start;
         if (frame_start) begin
            frame_crc <= acc_r;
         end
      end
   end

endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: recovers pixel coordinates from a VGA sync stream,
// verifies line/frame timing and reports locked, errors and frame counts.
// Optional feature: define VGA_MON_CRC_EN to compute a per-frame CRC-16
// of the active pixels; otherwise frame_crc and crc_valid are tied to 0.
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   red/green/blue      3-bit colour inputs
//   hsync, vsync        active-low sync inputs
//   pix_x, pix_y        active coordinate (0 when pix_valid is low)
//   pix_valid, pix_rgb  active-pixel strobe and {red,green,blue}
//   frame_start         one-cycle pulse at each good boundary while locked
//   locked              timing verified
//   h_err, v_err        sticky line / frame timing errors (cleared by reset)
//   frame_count         locked frames, wraps at 16 bits
//   frame_crc, crc_valid  per-frame CRC and its strobe
// Every output reflects the inputs present two clock edges earlier.
module vga_frame_monitor
   import vga_mon_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int H_START  = DEF_H_START,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int V_START  = DEF_V_START
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  red,
   input  logic [2:0]  green,
   input  logic [2:0]  blue,
   input  logic        hsync,
   input  logic        vsync,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        pix_valid,
   output logic [8:0]  pix_rgb,
   output logic        frame_start,
   output logic        locked,
   output logic        h_err,
   output logic        v_err,
   output logic [15:0] frame_count,
   output logic [15:0] frame_crc,
   output logic        crc_valid
);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_SAT  = 10'(H_TOTAL);
   localparam logic [9:0] H_LO   = 10'(H_START);
   localparam logic [9:0] H_HI   = 10'(H_START + H_ACTIVE);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SAT  = 10'(V_TOTAL);
   localparam logic [9:0] V_LO   = 10'(V_START);
   localparam logic [9:0] V_HI   = 10'(V_START + V_ACTIVE);

   mon_state_t  state_r, state_s;
   logic [8:0]  rgb_q_r;
   logic        hs_q_r, vs_q_r, hs_d_r, vs_d_r;
   logic [9:0]  h_cnt_r, h_cnt_s, v_cnt_r, v_cnt_s;
   logic        pending_r, pending_s, acq_err_r, acq_err_s;
   logic        line_start_s, pend_eff_s, boundary_s;
   logic        line_err_s, frame_err_s;
   logic        frame_ok_s, set_h_s, set_v_s, locked_s;
   logic        pix_valid_s;
   logic [9:0]  pix_x_s, pix_y_s;
   logic [8:0]  pix_rgb_s;
   logic [15:0] frame_count_r;

   assign frame_count = frame_count_r;

   // Input capture; the delayed syncs idle high so no edge is seen right after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q_r <= 9'd0;
         hs_q_r  <= 1'b1;
         vs_q_r  <= 1'b1;
         hs_d_r  <= 1'b1;
         vs_d_r  <= 1'b1;
      end else begin
         rgb_q_r <= {red, green, blue};
         hs_q_r  <= hsync;
         vs_q_r  <= vsync;
         hs_d_r  <= hs_q_r;
         vs_d_r  <= vs_q_r;
      end
   end

   // Sync edge detection, saturating counters and timing-error detection.
   always_comb begin
      line_start_s = hs_d_r & ~hs_q_r;
      pend_eff_s   = pending_r | (vs_d_r & ~vs_q_r);
      boundary_s   = line_start_s & pend_eff_s;
      h_cnt_s      = h_cnt_r;
      v_cnt_s      = v_cnt_r;
      pending_s    = pend_eff_s;
      line_err_s   = 1'b0;
      frame_err_s  = 1'b0;
      if (line_start_s) begin
         h_cnt_s    = 10'd0;
         line_err_s = (h_cnt_r != H_LAST);
      end else if (h_cnt_r >= H_SAT) begin
         h_cnt_s    = H_SAT;
      end else begin
         h_cnt_s    = h_cnt_r + 10'd1;
         // Flag once, on the step into saturation (missing line start).
         line_err_s = (h_cnt_r == H_LAST);
      end
      if (line_start_s) begin
         pending_s = 1'b0;
         if (pend_eff_s) begin
            v_cnt_s     = 10'd0;
            frame_err_s = (v_cnt_r != V_LAST);
         end else if (v_cnt_r >= V_SAT) begin
            v_cnt_s = V_SAT;
         end else begin
            v_cnt_s = v_cnt_r + 10'd1;
         end
      end else begin
         pending_s = pend_eff_s;
      end
   end

   // Lock FSM next state. Errors seen at the UNLOCKED->ACQUIRE boundary are
   // ignored; ACQUIRE needs one full clean frame, judged at its closing boundary.
   always_comb begin
      state_s    = state_r;
      acq_err_s  = acq_err_r;
      frame_ok_s = 1'b0;
      set_h_s    = 1'b0;
      set_v_s    = 1'b0;
      case (state_r)
         UNLOCKED: begin
            acq_err_s = 1'b0;
            if (boundary_s) begin
               state_s = ACQUIRE;
            end else begin
               state_s = UNLOCKED;
            end
         end
         ACQUIRE: begin
            if (boundary_s) begin
               acq_err_s = 1'b0;
               if ((acq_err_r | line_err_s | frame_err_s) == 1'b1) begin
                  state_s = ACQUIRE;
               end else begin
                  state_s    = LOCKED;
                  frame_ok_s = 1'b1;
               end
            end else begin
               acq_err_s = acq_err_r | line_err_s;
            end
         end
         LOCKED: begin
            if ((line_err_s | frame_err_s) == 1'b1) begin
               state_s = UNLOCKED;
               set_h_s = line_err_s;
               set_v_s = frame_err_s;
            end else if (boundary_s) begin
               frame_ok_s = 1'b1;
            end else begin
               frame_ok_s = 1'b0;
            end
         end
         default: begin
            state_s   = UNLOCKED;
            acq_err_s = 1'b0;
         end
      endcase
   end

   // Active-pixel window, evaluated on the counter values of the sample now in rgb_q_r.
   always_comb begin
      locked_s    = (state_s == LOCKED);
      pix_valid_s = 1'b0;
      pix_x_s     = 10'd0;
      pix_y_s     = 10'd0;
      pix_rgb_s   = 9'd0;
      if (locked_s && (h_cnt_s >= H_LO) && (h_cnt_s < H_HI) &&
          (v_cnt_s >= V_LO) && (v_cnt_s < V_HI)) begin
         pix_valid_s = 1'b1;
         pix_x_s     = h_cnt_s - H_LO;
         pix_y_s     = v_cnt_s - V_LO;
         pix_rgb_s   = rgb_q_r;
      end else begin
         pix_valid_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= UNLOCKED;
      end else begin
         state_r <= state_s;
      end
   end

   // Counters, status and registered pixel outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_r       <= 10'd0;
         v_cnt_r       <= 10'd0;
         pending_r     <= 1'b0;
         acq_err_r     <= 1'b0;
         pix_valid     <= 1'b0;
         pix_x         <= 10'd0;
         pix_y         <= 10'd0;
         pix_rgb       <= 9'd0;
         frame_start   <= 1'b0;
         locked        <= 1'b0;
         h_err         <= 1'b0;
         v_err         <= 1'b0;
         frame_count_r <= 16'd0;
      end else begin
         h_cnt_r     <= h_cnt_s;
         v_cnt_r     <= v_cnt_s;
         pending_r   <= pending_s;
         acq_err_r   <= acq_err_s;
         pix_valid   <= pix_valid_s;
         pix_x       <= pix_x_s;
         pix_y       <= pix_y_s;
         pix_rgb     <= pix_rgb_s;
         frame_start <= frame_ok_s;
         locked      <= locked_s;
         h_err       <= h_err | set_h_s;
         v_err       <= v_err | set_v_s;
         if (frame_ok_s) begin
            frame_count_r <= frame_count_r + 16'd1;
         end
      end
   end

`ifdef VGA_MON_CRC_EN
   logic crc_clear_s;
   assign crc_clear_s = ~locked_s;

   vga_mon_crc16 u_crc (
      .clk         (clk),
      .reset       (reset),
      .clear       (crc_clear_s),
      .pix_valid   (pix_valid_s),
      .pix_rgb     (pix_rgb_s),
      .frame_start (frame_ok_s),
      .frame_crc   (frame_crc),
      .crc_valid   (crc_valid)
   );
`else
   assign frame_crc = 16'd0;
   assign crc_valid = 1'b0;
`endif

endmodule

// File: doc/vga_frame_monitor.md
VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800: clocks per line.
REQ-003 SHALL have parameter H_START, default 144: first active h_cnt (sync 96 + back porch 48).
REQ-004 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-005 SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-006 SHALL have parameter V_START, default 35: first active v_cnt (sync 2 + back porch 33).
REQ-007 SHALL have port clk, input, 1: pixel clock, one pixel per cycle.
REQ-008 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-009 SHALL have ports red, green, blue, each input, 3: sampled pixel colour.
REQ-010 SHALL have ports hsync and vsync, each input, 1: active-low sync pulses.
REQ-011 SHALL have port pix_x, output, 10: active column, 0..H_ACTIVE-1.
REQ-012 SHALL have port pix_y, output, 10: active row, 0..V_ACTIVE-1.
REQ-013 SHALL have port pix_valid, output, 1: pix_x/pix_y/pix_rgb describe an active pixel.
REQ-014 SHALL have port pix_rgb, output, 9: {red,green,blue} of that pixel.
REQ-015 SHALL have port frame_start, output, 1: one-cycle pulse at frame boundary while LOCKED.
REQ-016 SHALL have port locked, output, 1: timing verified.
REQ-017 SHALL have ports h_err and v_err, each output, 1: sticky line/frame timing error.
REQ-018 SHALL have port frame_count, output, 16: frames seen while LOCKED.
REQ-019 SHALL have ports frame_crc (output, 16) and crc_valid (output, 1).

Function
REQ-020 SHALL register all inputs once; every output SHALL reflect inputs present two clk edges earlier.
REQ-021 SHALL detect a line start on an hsync 1->0 transition and set h_cnt=0 on it; otherwise h_cnt increments.
REQ-022 SHALL latch a vsync 1->0 transition as pending; the next line start (including the same cycle) SHALL set v_cnt=0 and clear pending; other line starts increment v_cnt.
REQ-023 SHALL implement FSM UNLOCKED -> ACQUIRE on first frame boundary; ACQUIRE -> LOCKED on next boundary if no line/frame error occurred; any error in ACQUIRE restarts ACQUIRE at that boundary.
REQ-024 SHALL flag a line error when a line start occurs with h_cnt != H_TOTAL-1, or h_cnt reaches H_TOTAL with no line start.
REQ-025 SHALL flag a frame error when a frame boundary occurs with v_cnt != V_TOTAL-1.
REQ-026 SHALL on a line error while LOCKED set h_err and go UNLOCKED; on a frame error while LOCKED set v_err and go UNLOCKED.
REQ-027 SHALL assert pix_valid only when LOCKED and H_START<=h_cnt<H_START+H_ACTIVE and V_START<=v_cnt<V_START+V_ACTIVE, with pix_x=h_cnt-H_START, pix_y=v_cnt-V_START.
REQ-028 SHALL hold pix_x, pix_y, pix_rgb at 0 when pix_valid is low.
REQ-029 SHALL pulse frame_start and increment frame_count (mod 2^16, wrap 0xFFFF->0) on every error-free boundary while LOCKED, including the ACQUIRE->LOCKED boundary.
REQ-030 SHALL saturate h_cnt at H_TOTAL and v_cnt at V_TOTAL to bound widths at 10 bits.

Reset
REQ-031 SHALL on reset set state UNLOCKED, counters, pending, pix_*, frame_start, locked, h_err, v_err, frame_count, frame_crc, crc_valid all to 0, and the input registers to hsync=vsync=1.
REQ-032 SHALL allow reset at any cycle, mid-line or mid-frame, with no edge detected on the first cycle after it.

Configuration
REQ-033 SHALL with VGA_MON_CRC_EN defined compute CRC-16-CCITT (poly 0x1021, init 0xFFFF) over pix_rgb zero-extended to 16 bits for every pix_valid pixel, present it on frame_crc with a one-cycle crc_valid at frame_start, then reinitialise.
REQ-034 SHALL without VGA_MON_CRC_EN tie frame_crc to 0 and crc_valid to 0.

Structure
REQ-035 SHALL place default timing constants and the FSM state encoding (UNLOCKED, ACQUIRE, LOCKED) in shared package vga_mon_pkg.
REQ-036 SHALL implement the CRC in sub-module vga_mon_crc16, instantiated only under VGA_MON_CRC_EN.

Verification
REQ-037 Two clean 800x525 frames -> locked=1 at second boundary, frame_start pulse, frame_count=1.
REQ-038 Locked; drive red=7,green=0,blue=5 at h_cnt=144,v_cnt=35 -> two cycles later pix_valid=1, pix_x=0, pix_y=0, pix_rgb=9'b111000101.
REQ-039 Locked; one line of 799 clocks -> h_err=1, locked=0, pix_valid=0 thereafter; h_err stays 1 until reset.
REQ-040 Locked; frame of 524 lines -> v_err=1, locked=0; resume clean timing -> relock after two boundaries, v_err still 1.
REQ-041 Preload 65535 frames locked -> next boundary frame_count=0.
REQ-042 VGA_MON_CRC_EN, all-zero frame -> crc_valid pulse with frame_crc matching golden model; reset mid-frame -> all outputs 0 next cycle.
